// File: rtl/parking_lot_controller_if.sv
// ---------------------------------------------------------------------------
// parking_lot_controller_if
// Bundles the gate-sensor/keypad requests and the status returned to the
// display and billing logic. Every signal here is synchronous to the
// controller's clk.
//   master : front-end side. Drives enter_req, exit_req and exit_number.
//   slave  : controller side. Drives entry_ready, enter_ack, enter_slot,
//            gate_open, park_location, free_count, full, empty, err_full
//            and err_exit.
// NUM_SLOTS must match the NUM_SLOTS of the controller attached to it.
// ---------------------------------------------------------------------------
interface parking_lot_controller_if #(
  parameter int NUM_SLOTS = 8
);
  localparam int IDX_W = $clog2(NUM_SLOTS);

  // Requests from the front-end
  logic             enter_req;
  logic             exit_req;
  logic [IDX_W-1:0] exit_number;

  // Status from the controller
  logic             entry_ready;
  logic             enter_ack;
  logic [IDX_W-1:0] enter_slot;
  logic             gate_open;
  logic [NUM_SLOTS-1:0] park_location;
  logic [IDX_W:0]   free_count;
  logic             full;
  logic             empty;
  logic             err_full;
  logic             err_exit;

  modport master (
    output enter_req, exit_req, exit_number,
    input  entry_ready, enter_ack, enter_slot, gate_open, park_location,
           free_count, full, empty, err_full, err_exit
  );

  modport slave (
    input  enter_req, exit_req, exit_number,
    output entry_ready, enter_ack, enter_slot, gate_open, park_location,
           free_count, full, empty, err_full, err_exit
  );
endinterface

// File: rtl/parking_lot_controller.sv
// ---------------------------------------------------------------------------
// parking_lot_controller
// Keeps a registered occupancy map of NUM_SLOTS spaces, hands the lowest
// free slot to each arriving car, frees slots on exit and runs the
// entry-gate timer.
// Ports:
//   clk    : single clock, rising edge.
//   rst_n  : synchronous active-low reset.
//   bus    : parking_lot_controller_if.slave. Carries the requests and all
//            status outputs.
//   total_entries, peak_occupancy : only present with PARKING_STATS_EN.
// Optional feature macro: PARKING_STATS_EN adds the accepted-entry counter,
// which saturates, and the running peak-occupancy register.
// ---------------------------------------------------------------------------
module parking_lot_controller #(
  parameter  int NUM_SLOTS   = 8,
  parameter  int GATE_CYCLES = 4,
  localparam int IDX_W       = $clog2(NUM_SLOTS)
) (
  input  logic clk,
  input  logic rst_n,
  parking_lot_controller_if.slave bus
`ifdef PARKING_STATS_EN
  ,
  output logic [15:0]    total_entries,
  output logic [IDX_W:0] peak_occupancy
`endif
);

  localparam int CNT_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

  typedef enum logic {ST_IDLE = 1'b0, ST_OPEN = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_SLOTS-1:0] map_q, map_d;
  logic [IDX_W:0]       free_count_q, free_count_d;
  logic                 full_q, full_d, empty_q, empty_d;
  logic                 ack_q, ack_d, err_full_q, err_full_d, err_exit_q, err_exit_d;
  logic [IDX_W-1:0]     slot_q, slot_d;

  logic [NUM_SLOTS-1:0] exit_onehot;
  logic [NUM_SLOTS-1:0] map_after_exit;
  logic                 exit_ok, entry_ok, free_found;
  logic [IDX_W-1:0]     alloc_idx;

  // One-hot decode of the slot being vacated
  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_exit_dec
    assign exit_onehot[gi] = (bus.exit_number == IDX_W'(gi));
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    ack_d          = 1'b0;
    err_full_d     = 1'b0;
    err_exit_d     = 1'b0;
    slot_d         = slot_q;
    entry_ok       = 1'b0;
    free_found     = 1'b0;
    alloc_idx      = '0;

    // Exit goes first so a slot freed this cycle can be reallocated at once.
    exit_ok        = bus.exit_req && ((map_q & exit_onehot) != '0);
    err_exit_d     = bus.exit_req && !exit_ok;
    map_after_exit = exit_ok ? (map_q & ~exit_onehot) : map_q;

    // Scan high to low so the last hit wins: that is the lowest free index.
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!map_after_exit[i]) begin
        free_found = 1'b1;
        alloc_idx  = IDX_W'(i);
      end
    end

    map_d = map_after_exit;

    case (state_q)
      ST_IDLE: begin
        if (bus.enter_req) begin
          if (free_found) begin
            entry_ok          = 1'b1;
            map_d[alloc_idx]  = 1'b1;
            ack_d             = 1'b1;
            slot_d            = alloc_idx;
            state_d           = ST_OPEN;
            cnt_d             = CNT_W'(GATE_CYCLES - 1);
          end else begin
            err_full_d = 1'b1;
          end
        end
      end
      ST_OPEN: begin
        // Entry requests are ignored while the barrier is up.
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    free_count_d = free_count_q + (IDX_W+1)'(exit_ok) - (IDX_W+1)'(entry_ok);
    full_d       = (free_count_d == '0);
    empty_d      = (free_count_d == (IDX_W+1)'(NUM_SLOTS));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      map_q        <= '0;
      free_count_q <= (IDX_W+1)'(NUM_SLOTS);
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      ack_q        <= 1'b0;
      err_full_q   <= 1'b0;
      err_exit_q   <= 1'b0;
      slot_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      map_q        <= map_d;
      free_count_q <= free_count_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      ack_q        <= ack_d;
      err_full_q   <= err_full_d;
      err_exit_q   <= err_exit_d;
      slot_q       <= slot_d;
    end
  end

  assign bus.entry_ready   = (state_q == ST_IDLE);
  assign bus.gate_open     = (state_q == ST_OPEN);
  assign bus.enter_ack     = ack_q;
  assign bus.enter_slot    = slot_q;
  assign bus.park_location = map_q;
  assign bus.free_count    = free_count_q;
  assign bus.full          = full_q;
  assign bus.empty         = empty_q;
  assign bus.err_full      = err_full_q;
  assign bus.err_exit      = err_exit_q;

`ifdef PARKING_STATS_EN
  logic [15:0]    total_q, total_d;
  logic [IDX_W:0] peak_q, peak_d;
  logic [IDX_W:0] occ_d;

  always_comb begin
    total_d = total_q;
    if (entry_ok && (total_q != 16'hFFFF)) begin
      total_d = total_q + 16'd1;
    end
    occ_d  = (IDX_W+1)'(NUM_SLOTS) - free_count_d;
    peak_d = (occ_d > peak_q) ? occ_d : peak_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      total_q <= '0;
      peak_q  <= '0;
    end else begin
      total_q <= total_d;
      peak_q  <= peak_d;
    end
  end

  assign total_entries  = total_q;
  assign peak_occupancy = peak_q;
`endif

endmodule
